tile_match_ctrl: RTL

Game controller for the six-tile image display. It accepts tile selections from the input layer, such as a mouse-click decoder, and runs a pair-matching state machine. It produces per-tile face-up and matched masks that configure what the six-tile image drawer shows for each slot: the image or a cover. Mismatched pairs stay visible for a frame-counted hold time, synchronised to the VGA vertical blank.

---
 rtl/tile_match_ctrl.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/tile_match_ctrl.sv
// Pair-matching game controller for the six-tile image display: accepts tile
// selections, tracks face-up / matched masks and holds mismatches for a number of frames.
module tile_match_ctrl #(
   parameter logic [17:0] PAIR_ID     = 18'o210210,
   parameter int unsigned HOLD_FRAMES = 60
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       vblnk,
   input  logic       start,
   input  logic       sel_valid,
   input  logic [2:0] sel_tile,
   output logic       sel_ack,
   output logic       sel_err,
   output logic [5:0] reveal_mask,
   output logic [5:0] matched_mask,
   output logic [7:0] move_count,
   output logic       busy,
   output logic       game_done
);

   typedef enum logic [2:0] {
      S_IDLE, S_WAIT1, S_WAIT2, S_CHECK, S_SHOW, S_DONE
   } state_t;

   localparam logic [7:0] HOLD_LAST = 8'(HOLD_FRAMES - 1);

   state_t     state, state_n;
   logic       start_q, sel_valid_q, vblnk_q, vblnk_rise_q;
   logic [2:0] sel_tile_q, first_idx, second_idx, first_idx_n, second_idx_n;
   logic [7:0] frame_cnt, frame_cnt_n, move_count_n;
   logic [5:0] reveal_n, matched_n;
   logic       ack_n, err_n, legal;

   function automatic logic [2:0] pair_of(input logic [2:0] t);
      case (t)
         3'd0:    return PAIR_ID[2:0];
         3'd1:    return PAIR_ID[5:3];
         3'd2:    return PAIR_ID[8:6];
         3'd3:    return PAIR_ID[11:9];
         3'd4:    return PAIR_ID[14:12];
         3'd5:    return PAIR_ID[17:15];
         default: return 3'd0;
      endcase
   endfunction

   assign legal = (sel_tile_q < 3'd6) && !matched_mask[sel_tile_q] && !reveal_mask[sel_tile_q];

   // Inputs and the vblnk edge are registered first, so every decision below
   // acts one cycle after the strobe is sampled.
   always_ff @(posedge clk) begin
      if (rst) begin
         start_q      <= 1'b0;
         sel_valid_q  <= 1'b0;
         sel_tile_q   <= 3'd0;
         vblnk_q      <= 1'b0;
         vblnk_rise_q <= 1'b0;
      end else begin
         start_q      <= start;
         sel_valid_q  <= sel_valid;
         sel_tile_q   <= sel_tile;
         vblnk_q      <= vblnk;
         vblnk_rise_q <= vblnk & ~vblnk_q;
      end
   end

   // NOTE: every state element updates with <= so all registers see the
   // pre-edge values of each other, regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= S_IDLE;
         first_idx    <= 3'd0;
         second_idx   <= 3'd0;
         frame_cnt    <= 8'd0;
         reveal_mask  <= 6'd0;
         matched_mask <= 6'd0;
         move_count   <= 8'd0;
         sel_ack      <= 1'b0;
         sel_err      <= 1'b0;
         busy         <= 1'b0;
         game_done    <= 1'b0;
      end else begin
         state        <= state_n;
         first_idx    <= first_idx_n;
         second_idx   <= second_idx_n;
         frame_cnt    <= frame_cnt_n;
         reveal_mask  <= reveal_n;
         matched_mask <= matched_n;
         move_count   <= move_count_n;
         sel_ack      <= ack_n;
         sel_err      <= err_n;
         busy         <= (state_n == S_CHECK) || (state_n == S_SHOW);
         game_done    <= (state_n == S_DONE);
      end
   end

   // NOTE: every output of this block gets a default before any branch, so no
   // path leaves a variable unassigned and no latch is inferred.
   always_comb begin
      state_n      = state;
      first_idx_n  = first_idx;
      second_idx_n = second_idx;
      frame_cnt_n  = frame_cnt;
      reveal_n     = reveal_mask;
      matched_n    = matched_mask;
      move_count_n = move_count;
      ack_n        = 1'b0;
      err_n        = 1'b0;

      if (start_q) begin
         state_n      = S_WAIT1;
         first_idx_n  = 3'd0;
         second_idx_n = 3'd0;
         frame_cnt_n  = 8'd0;
         reveal_n     = 6'd0;
         matched_n    = 6'd0;
         move_count_n = 8'd0;
      end else begin
         if (sel_valid_q) begin
            if ((state == S_WAIT1 || state == S_WAIT2) && legal) begin
               ack_n    = 1'b1;
               reveal_n = reveal_mask | (6'b000001 << sel_tile_q);
               if (state == S_WAIT1) begin
                  first_idx_n = sel_tile_q;
                  state_n     = S_WAIT2;
               end else begin
                  second_idx_n = sel_tile_q;
                  state_n      = S_CHECK;
               end
            end else begin
               err_n = 1'b1;
            end
         end

         case (state)
            S_CHECK: begin
               if (move_count != 8'hFF) move_count_n = move_count + 8'd1;
               if (pair_of(first_idx) == pair_of(second_idx)) begin
                  matched_n = matched_mask | (6'b000001 << first_idx) | (6'b000001 << second_idx);
                  state_n   = (matched_n == 6'b111111) ? S_DONE : S_WAIT1;
               end else begin
                  frame_cnt_n = 8'd0;
                  state_n     = S_SHOW;
               end
            end
            S_SHOW: begin
               if (vblnk_rise_q) begin
                  if (frame_cnt == HOLD_LAST) begin
                     reveal_n    = reveal_mask & ~((6'b000001 << first_idx) | (6'b000001 << second_idx));
                     frame_cnt_n = 8'd0;
                     state_n     = S_WAIT1;
                  end else begin
                     frame_cnt_n = frame_cnt + 8'd1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule
